// File: rtl/fifo_rd_stream_pkg.sv
// Shared occupancy encodings and counter width for the FIFO read-side word-to-beat streamer.
// Purely declarative: no latency and no backpressure behaviour of its own.
package fifo_rd_stream_pkg;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_t;

  localparam int BEAT_CNT_W = 32;

endpackage

// File: rtl/stream_unpack.sv
// Splits the head word into DWO-bit beats, most significant slice first, and flags the final slice.
// Zero latency (combinational from head word and index); the index holds while m_ready is low.
module stream_unpack #(
  parameter int DWF = 16,
  parameter int DWO = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [DWF-1:0] word,
  input  logic           valid,
  input  logic           ready,
  output logic [DWO-1:0] data,
  output logic           last,
  output logic           word_pop
);

  localparam int N  = DWF / DWO;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  logic [IW-1:0]  idx;
  logic           at_last;
  logic [DWO-1:0] slices [N];

  for (genvar k = 0; k < N; k++) begin : g_slice
    assign slices[k] = word[DWF-1-k*DWO -: DWO];
  end

  if (N == 1) begin : g_one
    assign data = slices[0];
  end else begin : g_many
    assign data = slices[idx];
  end

  // With N=1 the index is pinned at zero, so every beat is the last one.
  assign at_last  = (idx == LAST_IDX);
  assign last     = valid && at_last;
  assign word_pop = valid && ready && at_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (valid && ready) begin
      idx <= at_last ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rd_stream.sv
// Pops FIFO words into a 2-entry buffer and streams them as DWO-bit beats; first beat 2 clk after the pop.
// Pops stop once buffered plus in-flight words reach 2; FIFO_RD_STREAM_CNT_EN adds the beat_cnt output.
module fifo_rd_stream
  import fifo_rd_stream_pkg::*;
#(
  parameter int DWF = 16,
  parameter int DWO = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           fifo_empty,
  output logic           fifo_rd_en,
  input  logic [DWF-1:0] fifo_rd_data,
  output logic           m_valid,
  input  logic           m_ready,
  output logic [DWO-1:0] m_data,
  output logic           m_last
`ifdef FIFO_RD_STREAM_CNT_EN
  ,
  output logic [BEAT_CNT_W-1:0] beat_cnt
`endif
);

  occ_t           occ;
  logic           inflight;
  logic           armed;
  logic [DWF-1:0] buf0;
  logic [DWF-1:0] buf1;
  logic           word_pop;
  logic [1:0]     occ_base;
  logic [1:0]     occ_next;

  // occ_base: entries left after this cycle's pop, i.e. the slot an arriving word lands in.
  assign occ_base   = occ - {1'b0, word_pop};
  assign occ_next   = occ_base + {1'b0, inflight};
  assign fifo_rd_en = armed && !fifo_empty && (occ_next < 2'd2);
  assign m_valid    = (occ != OCC_EMPTY);

  // armed stays low through the release cycle so no pop can race the reset edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ      <= OCC_EMPTY;
      inflight <= 1'b0;
      armed    <= 1'b0;
      buf0     <= '0;
      buf1     <= '0;
    end else begin
      armed    <= 1'b1;
      inflight <= fifo_rd_en;
      occ      <= occ_t'(occ_next);
      if (word_pop) begin
        buf0 <= buf1;
      end
      if (inflight) begin
        if (occ_base == 2'd0) begin
          buf0 <= fifo_rd_data;
        end else begin
          buf1 <= fifo_rd_data;
        end
      end
    end
  end

  stream_unpack #(
    .DWF(DWF),
    .DWO(DWO)
  ) u_unpack (
    .clk     (clk),
    .rst     (rst),
    .word    (buf0),
    .valid   (m_valid),
    .ready   (m_ready),
    .data    (m_data),
    .last    (m_last),
    .word_pop(word_pop)
  );

`ifdef FIFO_RD_STREAM_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (m_valid && m_ready) begin
      beat_cnt <= beat_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: FIFO model plus beat scoreboard built from big-endian word splitting.
// A second instance with DWF=DWO exercises the one-slice-per-word case.
module tb_fifo_rd_stream;

  localparam int DWF = 16;
  localparam int DWO = 8;
  localparam int N   = DWF / DWO;

  typedef struct packed {
    logic [DWO-1:0] d;
    logic           l;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // main DUT and its FIFO model
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic [DWF-1:0] fifo_rd_data = '0;
  logic           m_valid;
  logic           m_ready = 1'b1;
  logic [DWO-1:0] m_data;
  logic           m_last;
  logic [DWF-1:0] mem [0:4095];
  int             wr_ptr = 0;
  int             rd_ptr = 0;
  int             pop_cnt = 0;
  logic           hold_empty = 1'b0;
  logic           flush = 1'b0;
  beat_t          exp_q[$];
  logic [8:0]     obs_q[$];
  int             first_pop_cyc = -1;
  int             first_valid_cyc = -1;

  // second DUT, one slice per word
  logic           f1_go = 1'b0;
  logic           f1_empty;
  logic           f1_rd_en;
  logic [7:0]     f1_rd_data = '0;
  logic           m1_valid;
  logic           m1_ready = 1'b1;
  logic [7:0]     m1_data;
  logic           m1_last;
  int             rd1 = 0;
  int             n1 = 0;
  int             first1 = 0;

`ifdef FIFO_RD_STREAM_CNT_EN
  logic [31:0]    beat_cnt;
  logic [31:0]    beat_cnt1;
`endif

  fifo_rd_stream #(.DWF(DWF), .DWO(DWO)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_rd_en  (fifo_rd_en),
    .fifo_rd_data(fifo_rd_data),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .m_last      (m_last)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt    (beat_cnt)
`endif
  );

  fifo_rd_stream #(.DWF(8), .DWO(8)) dut1 (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (f1_empty),
    .fifo_rd_en  (f1_rd_en),
    .fifo_rd_data(f1_rd_data),
    .m_valid     (m1_valid),
    .m_ready     (m1_ready),
    .m_data      (m1_data),
    .m_last      (m1_last)
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    .beat_cnt    (beat_cnt1)
`endif
  );

  assign fifo_empty = hold_empty || (rd_ptr == wr_ptr);
  assign f1_empty   = !f1_go || (rd1 >= 64);

  always @(posedge clk) begin
    if (flush) begin
      rd_ptr <= wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr       <= rd_ptr + 1;
      pop_cnt      <= pop_cnt + 1;
    end
    if (f1_rd_en && !f1_empty) begin
      f1_rd_data <= 8'(rd1);
      rd1        <= rd1 + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: a word becomes N beats, slice k taken from the top down.
  task automatic push_word(input logic [DWF-1:0] w);
    beat_t b;
    mem[wr_ptr] = w;
    wr_ptr++;
    for (int k = 0; k < N; k++) begin
      b.d = DWO'(w >> (DWF - DWO * (k + 1)));
      b.l = (k == N - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    chk(tag, 64'(exp_q.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (!rst) begin
      chk("rd_en_while_empty", 64'(fifo_rd_en && fifo_empty), 0);
      if (first_pop_cyc < 0 && fifo_rd_en && !fifo_empty) first_pop_cyc = cyc;
      if (first_valid_cyc < 0 && m_valid) first_valid_cyc = cyc;
      if (m_valid && m_ready) begin
        obs_q.push_back({m_data, m_last});
        vectors++;
        assert (exp_q.size() != 0) else begin
          miscompares++;
          $error("FAIL extra_beat observed=%0h expected=none", m_data);
        end
        if (exp_q.size() != 0) begin
          b = exp_q.pop_front();
          chk("beat_data", 64'(m_data), 64'(b.d));
          chk("beat_last", 64'(m_last), 64'(b.l));
        end
      end
      if (m1_valid && m1_ready) begin
        chk("n1_data", 64'(m1_data), 64'(n1));
        chk("n1_last", 64'(m1_last), 1);
        if (n1 == 0) first1 = cyc;
        else chk("n1_back_to_back", 64'(cyc), 64'(first1 + n1));
        n1++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0]     want [4];
    logic [DWO-1:0] held;
    logic           have;
    int             p0;
    int             n;

    want[0] = {8'hA1, 1'b0};
    want[1] = {8'hB2, 1'b1};
    want[2] = {8'hC3, 1'b0};
    want[3] = {8'hD4, 1'b1};

    // reset values with words already waiting in the FIFO
    push_word(16'hA1B2);
    push_word(16'hC3D4);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rd_en", 64'(fifo_rd_en), 0);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_data", 64'(m_data), 0);
    chk("rst_m_last", 64'(m_last), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    #1 chk("rd_en_release_cycle", 64'(fifo_rd_en), 0);

    // first-beat latency and big-endian order
    drain("latency_drain");
    chk("first_beat_latency", 64'(first_valid_cyc - first_pop_cyc), 2);
    chk("beat_count", 64'(obs_q.size()), 4);
    for (int k = 0; k < 4 && k < obs_q.size(); k++) chk("beat_order", 64'(obs_q[k]), 64'(want[k]));

    // single-slice words at full rate
    f1_go = 1'b1;
    n = 0;
    while (n1 < 64 && n < 300) begin
      @(posedge clk);
      n++;
    end
    #1 chk("n1_beats", 64'(n1), 64);

    // downstream stall with 8 words queued
    @(posedge clk);
    #1 m_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(16'h5000 + 16'(i * 16'h0123));
    p0   = pop_cnt;
    have = 1'b0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (m_valid) begin
        if (!have) begin
          held = m_data;
          have = 1'b1;
        end else begin
          chk("stall_m_data", 64'(m_data), 64'(held));
        end
      end
    end
    chk("stall_pops", 64'(pop_cnt - p0), 2);
    chk("stall_rd_en", 64'(fifo_rd_en), 0);
    chk("stall_valid", 64'(m_valid), 1);
    @(posedge clk);
    #1 m_ready = 1'b1;
    drain("stall_drain");

    // reset mid-operation with a word in flight
    @(posedge clk);
    #1 m_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_word(16'h7700 + 16'(i));
    p0 = pop_cnt;
    n  = 0;
    while ((pop_cnt - p0) < 2 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rst_setup_pops", 64'(pop_cnt - p0), 2);
    rst = 1'b1;
    #1;
    chk("midrst_rd_en", 64'(fifo_rd_en), 0);
    chk("midrst_m_valid", 64'(m_valid), 0);
    chk("midrst_m_data", 64'(m_data), 0);
    chk("midrst_m_last", 64'(m_last), 0);
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    push_word(16'h1E2F);
    push_word(16'h3A4B);
    @(posedge clk);
    #1 rst = 1'b0;
    m_ready = 1'b1;
    #1 chk("midrst_release_rd_en", 64'(fifo_rd_en), 0);
    drain("midrst_drain");

    // random FIFO gaps and random backpressure
    for (int i = 0; i < 1000; i++) push_word(DWF'($urandom));
    n = 0;
    while (exp_q.size() != 0 && n < 30000) begin
      @(posedge clk);
      #1;
      m_ready    = 1'($urandom_range(0, 1));
      hold_empty = ($urandom_range(0, 3) == 0);
      n++;
    end
    hold_empty = 1'b0;
    m_ready    = 1'b1;
    chk("random_drain", 64'(exp_q.size()), 0);
    repeat (3) @(posedge clk);
    #1;

`ifdef FIFO_RD_STREAM_CNT_EN
    rst   = 1'b1;
    flush = 1'b1;
    exp_q.delete();
    @(posedge clk);
    #1 flush = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 150; i++) push_word(DWF'($urandom));
    drain("cnt_drain");
    chk("beat_cnt_300", 64'(beat_cnt), 300);
    rst = 1'b1;
    #1 chk("beat_cnt_rst", 64'(beat_cnt), 0);
    @(posedge clk);
    #1 rst = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
